// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns one registered response pulse per command.
module apb_master_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WLAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wcnt;
  logic          accept, done, tmo;

  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    cmd_ready = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = prst;
        if (cmd_valid && prst) state_nxt = SETUP;
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        done      = pready;
        // Abort on the last permitted wait cycle; ready is low here anyway.
        tmo       = (TIMEOUT > 0) && !pready && (wcnt == WLAST);
        cmd_ready = prst && pready;
        if (pready)   state_nxt = (cmd_valid && prst) ? SETUP : IDLE;
        else if (tmo) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge pclk) begin
    if (!prst) begin
      state       <= IDLE;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      wcnt        <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end
      if (state == SETUP)
        wcnt <= '0;
      else if (state == ACCESS && !pready && wcnt != '1)
        wcnt <= wcnt + 1'b1;
      rsp_valid   <= done || tmo;
      rsp_rdata   <= (done && !pwrite) ? prdata : '0;
      rsp_err     <= done ? pslverr : tmo;
      rsp_timeout <= tmo;
    end
  end

endmodule
